// File: rtl/mux16_arbiter.sv
// 16-requester round-robin arbiter driving the select of a shared 16:1 mux.
// One owner at a time; release on done, request drop, or hold timeout.
module mux16_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        valid,
  output logic [3:0]  ptr
);

  localparam int          NREQ      = 16;
  localparam int unsigned SW        = 4;
  localparam int unsigned HW        = 8;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_gnt,   w_gnt_nxt;
  logic [SW-1:0] r_sel,   w_sel_nxt;
  logic          r_valid, w_valid_nxt;
  logic [SW-1:0] r_ptr,   w_ptr_nxt;
  logic [HW-1:0] r_hold,  w_hold_nxt;
  logic [SW-1:0] w_pick;
  logic          w_release;

  // First requesting index at or after the rotating pointer.
  always_comb begin
    w_pick = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[r_ptr + SW'(k)]) w_pick = r_ptr + SW'(k);
    end
  end

  assign w_release = done | ~req[r_sel] | (r_hold == HOLD_LAST);

  // State register together with the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req)     w_state_nxt = OWNED;
      OWNED:   if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and hold counter.
  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (|req) begin
          w_gnt_nxt   = 16'(1) << w_pick;
          w_sel_nxt   = w_pick;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      OWNED: begin
        if (w_release) begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_sel + SW'(1);
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt  = r_hold + HW'(1);
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;
  assign ptr   = r_ptr;

endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter: MAX_HOLD=8 and MAX_HOLD=1 instances share stimulus and
// are compared each cycle against a round-robin model; directed scenarios pin literals.
module tb_mux16_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic        done;

  logic [15:0] gnt8, gnt1;
  logic [3:0]  sel8, sel1, ptr8, ptr1;
  logic        valid8, valid1;

  int checks   = 0;
  int failures = 0;

  mux16_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt8), .sel(sel8), .valid(valid8), .ptr(ptr8)
  );

  mux16_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .ptr(ptr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (or none), rotating start index, cycles the owner has held.
  int limit [2] = '{8, 1};
  bit m_live = 1'b0;
  bit m_owned [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_held  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_owned[i] = 1'b0; m_sel[i] = 0; m_ptr[i] = 0; m_held[i] = 0;
      end else if (!m_owned[i]) begin
        if (req != 16'h0) begin
          for (int k = 15; k >= 0; k--)
            if (req[(m_ptr[i] + k) % 16]) m_sel[i] = (m_ptr[i] + k) % 16;
          m_owned[i] = 1'b1;
          m_held[i]  = 1;
        end
      end else begin
        if (done || !req[m_sel[i]] || m_held[i] >= limit[i]) begin
          m_owned[i] = 1'b0;
          m_ptr[i]   = (m_sel[i] + 1) % 16;
        end else begin
          m_held[i]  = m_held[i] + 1;
        end
      end
    end
    if (reset) m_live = 1'b1;
  end

  task automatic cmp_inst(input int i, input logic [15:0] g, input logic [3:0] s,
                          input logic v, input logic [3:0] p);
    logic [15:0] eg;
    eg = m_owned[i] ? (16'(1) << m_sel[i]) : 16'h0;
    chk($sformatf("m%0d_gnt", i),   g, eg);
    chk($sformatf("m%0d_sel", i),   16'(s), 16'(m_sel[i]));
    chk($sformatf("m%0d_valid", i), 16'(v), 16'(m_owned[i]));
    chk($sformatf("m%0d_ptr", i),   16'(p), 16'(m_ptr[i]));
    chk($sformatf("m%0d_vld_or", i), 16'(v), 16'(|g));
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (m_live) begin
      cmp_inst(0, gnt8, sel8, valid8, ptr8);
      cmp_inst(1, gnt1, sel1, valid1, ptr1);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req = 16'h0; done = 1'b0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    chk("rst_gnt", gnt8, 16'h0);
    chk("rst_sel", 16'(sel8), 16'h0);
    chk("rst_valid", 16'(valid8), 16'h0);
    chk("rst_ptr", 16'(ptr8), 16'h0);

    // Single requester, done in third granted cycle.
    req = 16'h0001;
    step();
    chk("basic_gnt", gnt8, 16'h0001);
    chk("basic_sel", 16'(sel8), 16'h0);
    chk("basic_valid", 16'(valid8), 16'h1);
    step(); step();
    chk("basic_gnt3", gnt8, 16'h0001);
    done = 1'b1;
    step();
    chk("basic_rel_gnt", gnt8, 16'h0);
    chk("basic_rel_ptr", 16'(ptr8), 16'h1);
    done = 1'b0; req = 16'h0;
    step();

    // Fairness sweep from ptr 0.
    reset = 1'b1; step(); reset = 1'b0;
    req = 16'hFFFF; done = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      step();
      chk("fair_sel", 16'(sel8), 16'(i % 16));
      chk("fair_gnt", gnt8, 16'(1) << (i % 16));
      step();
      chk("fair_idle", 16'(valid8), 16'h0);
    end

    // Wrap from ptr 14.
    req = 16'h2000;
    step(); step();
    chk("wrap_ptr14", 16'(ptr8), 16'd14);
    req = 16'h0003;
    step(); chk("wrap_sel0", 16'(sel8), 16'd0);
    step(); chk("wrap_ptr1", 16'(ptr8), 16'd1);
    step(); chk("wrap_sel1", 16'(sel8), 16'd1);
    step(); chk("wrap_ptr2", 16'(ptr8), 16'd2);

    // Timeout with MAX_HOLD=8.
    req = 16'h0010; done = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("tmo_gnt", gnt8, 16'h0010);
      step();
    end
    chk("tmo_idle", 16'(valid8), 16'h0);
    chk("tmo_ptr", 16'(ptr8), 16'd5);
    step();
    chk("tmo_regnt", gnt8, 16'h0010);

    // Request drop handing over to 9.
    req = 16'h0020;
    step();
    step();
    chk("drop_own5", gnt8, 16'h0020);
    req = 16'h0220;
    step();
    chk("drop_ignore", 16'(sel8), 16'd5);
    req = 16'h0200;
    step();
    chk("drop_rel", gnt8, 16'h0);
    step();
    chk("drop_gnt9", gnt8, 16'h0200);
    chk("drop_sel9", 16'(sel8), 16'd9);

    // Reset mid-grant of owner 7.
    req = 16'h0080;
    step(); step();
    chk("mid_own7", 16'(sel8), 16'd7);
    req = 16'h8080;
    step();
    reset = 1'b1;
    step();
    chk("mid_gnt", gnt8, 16'h0);
    chk("mid_valid", 16'(valid8), 16'h0);
    chk("mid_ptr", 16'(ptr8), 16'h0);
    reset = 1'b0;
    step();
    chk("mid_regnt", gnt8, 16'h0080);
    chk("mid_sel7", 16'(sel8), 16'd7);

    // Randomized traffic, checked by the model process.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: req = 16'h0;
        1: req = 16'(1) << $urandom_range(0, 15);
        2: req = 16'($urandom);
        default: ;
      endcase
      done  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
